// File: rtl/serial_sub.sv
// ---------------------------------------------------------------------------
// serial_sub : digit-serial unsigned subtractor.
//
// Computes sub_in1 - sub_in2 (mod 2^BUS_WIDTH) one DIGIT_WIDTH-bit digit per
// clock, least significant digit first, and reports the final borrow. One
// operation is in flight at a time. The block takes N = BUS_WIDTH/DIGIT_WIDTH
// CALC cycles and then holds the result until the consumer accepts it.
//
// Ports
//   clk, rst        : clock and synchronous active-high reset
//   sub_in_valid    : operands valid          (in)
//   sub_in_ready    : block is idle and accepts operands (out)
//   sub_in1/sub_in2 : minuend / subtrahend, unsigned     (in)
//   sub_out_valid   : result valid            (out)
//   sub_out_ready   : consumer accepts result (in)
//   sub_out         : difference, registered  (out)
//   sub_borrow_out  : 1 iff sub_in1 < sub_in2, registered (out)
// ---------------------------------------------------------------------------
module serial_sub #(
    parameter int BUS_WIDTH   = 32,
    parameter int DIGIT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sub_in_valid,
    output logic                 sub_in_ready,
    input  logic [BUS_WIDTH-1:0] sub_in1,
    input  logic [BUS_WIDTH-1:0] sub_in2,
    output logic                 sub_out_valid,
    input  logic                 sub_out_ready,
    output logic [BUS_WIDTH-1:0] sub_out,
    output logic                 sub_borrow_out
);

    localparam int N  = BUS_WIDTH / DIGIT_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state, state_nx;
    logic [BUS_WIDTH-1:0]   a_sh, b_sh;   // operands, shifted down one digit per CALC cycle
    logic [CW-1:0]          cnt;          // index of the digit being processed
    logic                   borrow;       // borrow carried between digits
    logic [DIGIT_WIDTH:0]   diff;         // one extra bit catches the digit borrow
    logic                   last;
    int                     dig_lsb;

    assign last    = (cnt == CW'(N - 1));
    assign dig_lsb = int'(cnt) * DIGIT_WIDTH;

    always_comb begin
        diff = {1'b0, a_sh[DIGIT_WIDTH-1:0]}
             - {1'b0, b_sh[DIGIT_WIDTH-1:0]}
             - {{DIGIT_WIDTH{1'b0}}, borrow};
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sub_in_valid)  state_nx = CALC;
            CALC:    if (last)          state_nx = DONE;
            DONE:    if (sub_out_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        sub_in_ready  = (state == IDLE);
        sub_out_valid = (state == DONE);
    end

    // ---------------- datapath ----------------
    // The result register is written digit by digit in place; its contents
    // are only meaningful once DONE is reached, and it keeps the last result
    // through the return to IDLE until the next operation overwrites it.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh           <= '0;
            b_sh           <= '0;
            cnt            <= '0;
            borrow         <= 1'b0;
            sub_out        <= '0;
            sub_borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sub_in_valid) begin
                        a_sh   <= sub_in1;
                        b_sh   <= sub_in2;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    sub_out[dig_lsb +: DIGIT_WIDTH] <= diff[DIGIT_WIDTH-1:0];
                    borrow <= diff[DIGIT_WIDTH];
                    a_sh   <= a_sh >> DIGIT_WIDTH;
                    b_sh   <= b_sh >> DIGIT_WIDTH;
                    if (last) begin
                        cnt            <= '0;
                        sub_borrow_out <= diff[DIGIT_WIDTH];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_sub : directed bench for serial_sub (default parameters).
// A transaction-level model (whole-word subtraction plus an operation timer)
// is checked against the DUT on every falling edge; directed sequences add
// hand-computed literal checks on results, latency and accept spacing.
// ---------------------------------------------------------------------------
module tb_serial_sub;

    localparam int W = 32;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sub_in_valid = 1'b0;
    logic         sub_in_ready;
    logic [W-1:0] sub_in1 = '0;
    logic [W-1:0] sub_in2 = '0;
    logic         sub_out_valid;
    logic         sub_out_ready = 1'b0;
    logic [W-1:0] sub_out;
    logic         sub_borrow_out;

    serial_sub #(.BUS_WIDTH(W), .DIGIT_WIDTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .sub_in_valid   (sub_in_valid),
        .sub_in_ready   (sub_in_ready),
        .sub_in1        (sub_in1),
        .sub_in2        (sub_in2),
        .sub_out_valid  (sub_out_valid),
        .sub_out_ready  (sub_out_ready),
        .sub_out        (sub_out),
        .sub_borrow_out (sub_borrow_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    // m_phase: 0 = idle, 1..N = cycles spent computing, N+1 = result presented
    int          cyc = 0;
    int          m_phase = 0;
    logic [W:0]  m_pend = '0;
    logic [W-1:0] m_out = '0;
    logic        m_bor = 1'b0;
    int          acc_q[$];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_phase = 0;
            m_out   = '0;
            m_bor   = 1'b0;
        end else if (m_phase == 0) begin
            if (sub_in_valid) begin
                m_pend  = {1'b0, sub_in1} - {1'b0, sub_in2};
                m_phase = 1;
                acc_q.push_back(cyc);
            end
        end else if (m_phase <= N) begin
            m_phase++;
            if (m_phase == N + 1) begin
                m_out = m_pend[W-1:0];
                m_bor = m_pend[W];
            end
        end else if (sub_out_ready) begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("model_in_ready",  64'(sub_in_ready),  64'(m_phase == 0));
            chk("model_out_valid", 64'(sub_out_valid), 64'(m_phase == N + 1));
            if (m_phase == 0 || m_phase == N + 1) begin
                chk("model_out",    64'(sub_out),        64'(m_out));
                chk("model_borrow", 64'(sub_borrow_out), 64'(m_bor));
            end
        end
    end

    // ---------------- directed helpers ----------------
    // Present operands on a falling edge, then wait (bounded) for the result.
    // Returns the number of rising edges from acceptance to out_valid.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        sub_in1      = a;
        sub_in2      = b;
        sub_in_valid = 1'b1;
        @(negedge clk);             // accepting edge has passed
        sub_in_valid = 1'b0;
        sub_in1      = 32'hA5A5_5A5A;   // must not disturb the captured operands
        sub_in2      = 32'h1234_4321;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!sub_out_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input logic exp_b);
        int k;
        sub_out_ready = 1'b1;
        start_op(a, b);
        wait_valid(k);
        chk({name, "_latency"}, 64'(k), 64'(N));
        chk({name, "_out"},     64'(sub_out), 64'(exp));
        chk({name, "_borrow"},  64'(sub_borrow_out), 64'(exp_b));
        @(negedge clk);
        chk({name, "_pulse_width"}, 64'(sub_out_valid), 64'd0);
    endtask

    initial begin
        int k;
        logic [W-1:0] got[$];

        // reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready",  64'(sub_in_ready),   64'd1);
        chk("reset_out_valid", 64'(sub_out_valid),  64'd0);
        chk("reset_out",       64'(sub_out),        64'd0);
        chk("reset_borrow",    64'(sub_borrow_out), 64'd0);

        run_op("five_minus_three", 32'd5,          32'd3,          32'h0000_0002, 1'b0);
        run_op("zero_minus_one",   32'd0,          32'd1,          32'hFFFF_FFFF, 1'b1);
        run_op("borrow_chain",     32'h0001_0000,  32'h0000_0001,  32'h0000_FFFF, 1'b0);
        run_op("equal",            32'hDEAD_BEEF,  32'hDEAD_BEEF,  32'h0000_0000, 1'b0);
        run_op("msb",              32'h8000_0000,  32'h7FFF_FFFF,  32'h0000_0001, 1'b0);

        // result held across idle until the next operation
        repeat (3) @(negedge clk);
        chk("idle_hold_out", 64'(sub_out), 64'h1);

        // backpressure with new operands waiting
        sub_out_ready = 1'b0;
        start_op(32'd9, 32'd4);
        wait_valid(k);
        chk("bp_latency", 64'(k), 64'(N));
        sub_in1      = 32'h10;
        sub_in2      = 32'h20;
        sub_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",    64'(sub_out_valid),  64'd1);
            chk("bp_in_ready", 64'(sub_in_ready),   64'd0);
            chk("bp_out",      64'(sub_out),        64'd5);
            chk("bp_borrow",   64'(sub_borrow_out), 64'd0);
            @(negedge clk);
        end
        sub_out_ready = 1'b1;
        @(negedge clk);             // handshake edge -> idle
        chk("bp_after_hs_ready", 64'(sub_in_ready), 64'd1);
        @(negedge clk);             // waiting operands accepted here
        sub_in_valid = 1'b0;
        chk("bp_new_accepted", 64'(sub_in_ready), 64'd0);
        wait_valid(k);
        chk("bp_new_latency", 64'(k), 64'(N));
        chk("bp_new_out",     64'(sub_out), 64'hFFFF_FFF0);
        chk("bp_new_borrow",  64'(sub_borrow_out), 64'd1);
        @(negedge clk);

        // reset on the 4th CALC edge
        start_op(32'h1234_5678, 32'h0000_0001);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", 64'(sub_out_valid),  64'd0);
        chk("abort_in_ready",  64'(sub_in_ready),   64'd1);
        chk("abort_out",       64'(sub_out),        64'd0);
        chk("abort_borrow",    64'(sub_borrow_out), 64'd0);
        run_op("after_abort", 32'd100, 32'd200, 32'hFFFF_FF9C, 1'b1);

        // back-to-back with valid/ready held high
        acc_q.delete();
        @(negedge clk);
        sub_out_ready = 1'b1;
        sub_in1       = 32'd7;
        sub_in2       = 32'd2;
        sub_in_valid  = 1'b1;
        @(negedge clk);
        sub_in1 = 32'h1000;
        sub_in2 = 32'h1;
        for (int i = 0; i < 40 && got.size() < 2; i++) begin
            if (sub_out_valid) got.push_back(sub_out);
            if (acc_q.size() >= 2) sub_in_valid = 1'b0;
            @(negedge clk);
        end
        sub_in_valid = 1'b0;
        chk("b2b_accepts", 64'(acc_q.size()), 64'd2);
        chk("b2b_results", 64'(got.size()),   64'd2);
        if (acc_q.size() >= 2) chk("b2b_spacing", 64'(acc_q[1] - acc_q[0]), 64'd10);
        if (got.size() >= 2) begin
            chk("b2b_out0", 64'(got[0]), 64'd5);
            chk("b2b_out1", 64'(got[1]), 64'hFFF);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter BUS_WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter DIGIT_WIDTH, default 4: bits processed per CALC cycle; BUS_WIDTH SHALL be an integer multiple of DIGIT_WIDTH.
REQ-003 Derived constant N = BUS_WIDTH/DIGIT_WIDTH SHALL be the number of CALC cycles per operation (8 at defaults).
REQ-004 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 sub_in_valid  input  1: operands valid.
REQ-007 sub_in_ready  output  1: block can accept operands.
REQ-008 sub_in1  input  BUS_WIDTH: minuend, unsigned.
REQ-009 sub_in2  input  BUS_WIDTH: subtrahend, unsigned.
REQ-010 sub_out_valid  output  1: result valid.
REQ-011 sub_out_ready  input  1: consumer accepts result.
REQ-012 sub_out  output  BUS_WIDTH: difference sub_in1 - sub_in2 modulo 2^BUS_WIDTH.
REQ-013 sub_borrow_out  output  1: final borrow; 1 iff sub_in1 < sub_in2.

Function
REQ-014 FSM states SHALL be IDLE, CALC, DONE.
REQ-015 sub_in_ready SHALL be 1 exactly when state is IDLE; sub_out_valid SHALL be 1 exactly when state is DONE.
REQ-016 IDLE: on sub_in_valid=1 at an edge, operands SHALL be captured into internal registers, borrow cleared, digit counter set to 0, state -> CALC; otherwise remain IDLE.
REQ-017 sub_in_valid while sub_in_ready=0 SHALL be ignored; input changes after capture SHALL NOT affect the result.
REQ-018 CALC, each edge: digit k = counter; diff_k = a_k - b_k - borrow (DIGIT_WIDTH+1-bit arithmetic); low DIGIT_WIDTH bits SHALL be written to result bits [k*DIGIT_WIDTH +: DIGIT_WIDTH]; borrow SHALL take bit DIGIT_WIDTH of diff_k; counter increments.
REQ-019 On the edge processing digit N-1, state SHALL -> DONE and counter SHALL return to 0.
REQ-020 Latency: sub_out_valid SHALL rise exactly N clock edges after the accepting edge (8 at defaults).
REQ-021 DONE: sub_out and sub_borrow_out SHALL be driven from registers and held stable while sub_out_ready=0, for any number of cycles.
REQ-022 DONE with sub_out_ready=1 at an edge: state -> IDLE; sub_out/sub_borrow_out SHALL retain last values until the next result overwrites them.
REQ-023 Throughput: at most one operation in flight; minimum initiation interval N+2 cycles (accept, N CALC, DONE handshake returns to IDLE).
REQ-024 sub_out_ready in IDLE or CALC SHALL have no effect.
REQ-025 Borrow SHALL propagate across digit boundaries; sub_borrow_out SHALL equal the borrow after digit N-1.
REQ-026 Bits of sub_out not yet written during CALC are don't-care externally; only values during sub_out_valid=1 are specified.

Reset
REQ-027 rst=1 at an edge SHALL force state IDLE, counter 0, internal borrow 0, sub_out 0, sub_borrow_out 0, regardless of state; sub_out_valid=0, sub_in_ready=1 from the following cycle.
REQ-028 rst asserted mid-CALC or in DONE SHALL abort the operation with no result ever presented.
REQ-029 rst SHALL take priority over sub_in_valid and sub_out_ready on the same edge.

Verification
REQ-030 5 - 3, out_ready=1 -> sub_out=0x00000002, borrow 0, sub_out_valid high exactly 8 edges after accept, 1 cycle wide.
REQ-031 0 - 1 -> sub_out=0xFFFFFFFF, borrow 1; 0x00010000 - 0x00000001 -> 0x0000FFFF, borrow 0 (multi-digit borrow chain).
REQ-032 0xDEADBEEF - 0xDEADBEEF -> 0x00000000, borrow 0; 0x80000000 - 0x7FFFFFFF -> 0x00000001, borrow 0.
REQ-033 Backpressure: out_ready=0 for 5 cycles in DONE, sub_in_valid=1 with new operands -> sub_out, borrow, sub_out_valid=1, sub_in_ready=0 stable; new operands not taken until after out handshake + IDLE.
REQ-034 Reset on 4th CALC edge of 0x12345678 - 0x00000001 -> next cycle sub_out_valid=0, sub_in_ready=1, sub_out=0; then 100 - 200 -> 0xFFFFFF9C, borrow 1.
REQ-035 Back-to-back: 2 operations with in_valid and out_ready held high -> accepts spaced exactly 10 cycles, both results correct.
